// File: rtl/rx_frame_buffer_pkg.sv
// Shared definitions for the pixel path: default image geometry and pixel type.
// Used by the receiver, the frame buffer and the filter pipeline.
package rx_frame_buffer_pkg;

    localparam int DEF_RGB_WIDTH  = 24;
    localparam int DEF_IMG_WIDTH  = 80;
    localparam int DEF_IMG_HEIGHT = 120;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef logic [DEF_RGB_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: DEPTH x WIDTH RAM, one synchronous write port and one
// registered read port. Ports: clk, i_we/i_waddr/i_wdata, i_re/i_raddr, o_rdata.
module frame_bank_ram #(
    parameter int DEPTH = 9600,
    parameter int WIDTH = 24,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read output only updates on i_re, so it holds between reads.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_frame_buffer.sv
// Ping-pong frame store between the pixel receiver and the image pipeline.
// Ports: write side (we/wData/wAddr/frame_done), read side (oe/rAddr/imgData/
// rvalid/rd_release), status (o_frame_done, frame_valid, overflow, drop_cnt).
module rx_frame_buffer
    import rx_frame_buffer_pkg::*;
#(
    parameter int RGB_WIDTH    = DEF_RGB_WIDTH,
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS),
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [RGB_WIDTH-1:0]  wData,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic                  frame_done,
    output logic                  o_frame_done,
    output logic                  frame_valid,
    input  logic                  rd_release,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    output logic [RGB_WIDTH-1:0]  imgData,
    output logic                  rvalid,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);

    logic                 r_wr_bank;
    logic                 r_front_valid;
    logic                 r_back_pending;
    logic                 r_frame_done;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic                 r_rvalid;
    logic                 r_rd_sel;
    logic                 r_rd_zero;

    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_we0;
    logic                 w_we1;
    logic                 w_re0;
    logic                 w_re1;
    logic [RGB_WIDTH-1:0] w_rdata0;
    logic [RGB_WIDTH-1:0] w_rdata1;
    logic                 w_swap_fd;
    logic                 w_swap_rel;

    // Writes go to the bank owned at this edge, so a write coinciding with
    // a swap lands in the pre-swap back bank.
    assign w_wr_ok = we && !r_back_pending && (wAddr <= LAST_ADDR);
    assign w_we0   = w_wr_ok && !r_wr_bank;
    assign w_we1   = w_wr_ok &&  r_wr_bank;

    // Front bank is always the one not being written.
    assign w_rd_ok = oe && (rAddr <= LAST_ADDR);
    assign w_re0   = w_rd_ok &&  r_wr_bank;
    assign w_re1   = w_rd_ok && !r_wr_bank;

    frame_bank_ram #(
        .DEPTH (TOTAL_PIXELS),
        .WIDTH (RGB_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_waddr (wAddr),
        .i_wdata (wData),
        .i_re    (w_re0),
        .i_raddr (rAddr),
        .o_rdata (w_rdata0)
    );

    frame_bank_ram #(
        .DEPTH (TOTAL_PIXELS),
        .WIDTH (RGB_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_waddr (wAddr),
        .i_wdata (wData),
        .i_re    (w_re1),
        .i_raddr (rAddr),
        .o_rdata (w_rdata1)
    );

    // Immediate swap on frame_done when the front is free or being released
    // this same cycle; deferred swap when a pending frame meets a release.
    assign w_swap_fd  = frame_done && (!r_front_valid || rd_release);
    assign w_swap_rel = !frame_done && rd_release && r_back_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank      <= 1'b0;
            r_front_valid  <= 1'b0;
            r_back_pending <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            r_frame_done <= w_swap_fd || w_swap_rel;

            if (we && r_back_pending) begin
                r_overflow <= 1'b1;
            end

            if (w_swap_fd) begin
                r_wr_bank      <= ~r_wr_bank;
                r_front_valid  <= 1'b1;
                r_back_pending <= 1'b0;
            end else if (frame_done && !r_back_pending) begin
                r_back_pending <= 1'b1;
            end else if (frame_done) begin
                // Back bank already holds a frame waiting for the reader.
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                end
            end else if (w_swap_rel) begin
                r_wr_bank      <= ~r_wr_bank;
                r_back_pending <= 1'b0;
            end else if (rd_release) begin
                r_front_valid <= 1'b0;
            end
        end
    end

    // Read pipeline: remember which bank was read and whether the address
    // was out of range; both hold while oe is low so imgData holds too.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_rvalid <= oe;
            if (oe) begin
                r_rd_sel  <= ~r_wr_bank;
                r_rd_zero <= !w_rd_ok;
            end
        end
    end

    assign imgData      = r_rd_zero ? '0 : (r_rd_sel ? w_rdata1 : w_rdata0);
    assign rvalid       = r_rvalid;
    assign o_frame_done = r_frame_done;
    assign frame_valid  = r_front_valid;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;

endmodule
